// File: rtl/matrix_multiply_check.sv
// Sequential fixed-point N x N matrix multiplier, C = A x B.
// Operands stream in row-major (A then B), one MAC per cycle, results
// stream out row-major with saturation to the DATA_W range.
// Optional build macro: IDENTITY_CHECK_EN adds the is_identity output and
// the TOL parameter, which grade the product against the identity matrix.
//
// state  | meaning
// S_LOAD | accepting 2*N*N operand words, in_ready high
// S_MAC  | accumulating A[i][k]*B[k][j] for k = 0..N-1
// S_EMIT | presenting C[i][j], waiting for out_ready
module matrix_multiply_check #(
  parameter int N      = 5,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
`ifdef IDENTITY_CHECK_EN
  , parameter int TOL  = 2
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        out_row,
  output logic [2:0]        out_col,
  output logic              out_last,
  output logic              sat_flag,
  output logic              busy
`ifdef IDENTITY_CHECK_EN
  , output logic            is_identity
`endif
);

  localparam int NN    = N * N;
  localparam int ACC_W = 2 * DATA_W + $clog2(N);
  localparam int AW    = $clog2(NN);
  localparam int LW    = $clog2(2 * NN);

  localparam logic [LW-1:0] LD_LAST  = LW'(2 * NN - 1);
  localparam logic [LW-1:0] LD_B0    = LW'(NN);
  localparam logic [2:0]    IDX_LAST = 3'(N - 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic [DATA_W-1:0] RES_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] RES_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_LOAD, S_MAC, S_EMIT} state_t;

  state_t                    state_q;
  logic [LW-1:0]             ld_cnt_q;
  logic [2:0]                i_q, j_q, k_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic                      in_ready_q, out_valid_q, out_last_q, sat_q, busy_q;
  logic [DATA_W-1:0]         out_data_q;
  logic [2:0]                out_row_q, out_col_q;

  logic signed [DATA_W-1:0]  a_mem [NN];
  logic signed [DATA_W-1:0]  b_mem [NN];

  logic                      hs_in, hs_out;
  logic [AW-1:0]             ld_addr, a_addr, b_addr;
  logic signed [DATA_W-1:0]  a_el, b_el;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]   acc_d, acc_sh;
  logic                      clamp_hi, clamp_lo;
  logic [DATA_W-1:0]         res_d;

  assign hs_in   = (state_q == S_LOAD) && in_valid && in_ready_q;
  assign hs_out  = (state_q == S_EMIT) && out_ready;
  assign ld_addr = (ld_cnt_q < LD_B0) ? AW'(ld_cnt_q) : AW'(ld_cnt_q - LD_B0);
  assign a_addr  = AW'(i_q * N + k_q);
  assign b_addr  = AW'(k_q * N + j_q);
  assign a_el    = a_mem[a_addr];
  assign b_el    = b_mem[b_addr];

  // One product term per cycle; the accumulator is wide enough that the
  // sum of N full-scale products cannot wrap, so only the output clamps.
  assign prod     = (2*DATA_W)'(a_el) * (2*DATA_W)'(b_el);
  assign acc_d    = acc_q + ACC_W'(prod);
  assign acc_sh   = acc_d >>> FRAC_W;
  assign clamp_hi = acc_sh > SAT_MAX;
  assign clamp_lo = acc_sh < SAT_MIN;
  assign res_d    = clamp_hi ? RES_MAX : (clamp_lo ? RES_MIN : acc_sh[DATA_W-1:0]);

`ifdef IDENTITY_CHECK_EN
  localparam logic signed [DATA_W:0] ONE_V = (DATA_W+1)'(1 <<< FRAC_W);
  localparam logic signed [DATA_W:0] TOL_V = (DATA_W+1)'(TOL);

  logic                      elem_sat_q, ident_run_q, is_identity_q;
  logic signed [DATA_W:0]    id_exp, id_diff, id_abs;
  logic                      elem_ok;

  assign id_exp  = (out_row_q == out_col_q) ? ONE_V : '0;
  assign id_diff = $signed({out_data_q[DATA_W-1], out_data_q}) - id_exp;
  assign id_abs  = id_diff[DATA_W] ? -id_diff : id_diff;
  assign elem_ok = !elem_sat_q && (id_abs <= TOL_V);
  assign is_identity = is_identity_q;
`endif

  // Operand storage; contents are don't-care until a full load completes.
  always_ff @(posedge clk) begin
    if (hs_in) begin
      if (ld_cnt_q < LD_B0) a_mem[ld_addr] <= in_data;
      else                  b_mem[ld_addr] <= in_data;
    end
  end

  // Sequencer with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LOAD;
      ld_cnt_q    <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_last_q  <= 1'b0;
      sat_q       <= 1'b0;
      busy_q      <= 1'b0;
`ifdef IDENTITY_CHECK_EN
      elem_sat_q    <= 1'b0;
      ident_run_q   <= 1'b0;
      is_identity_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_LOAD: begin
          if (hs_in) begin
            if (ld_cnt_q == LD_LAST) begin
              state_q    <= S_MAC;
              ld_cnt_q   <= '0;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
              acc_q      <= '0;
              i_q        <= '0;
              j_q        <= '0;
              k_q        <= '0;
              sat_q      <= 1'b0;
`ifdef IDENTITY_CHECK_EN
              ident_run_q <= 1'b1;
`endif
            end else begin
              ld_cnt_q <= ld_cnt_q + 1'b1;
            end
          end
        end
        S_MAC: begin
          acc_q <= acc_d;
          if (k_q == IDX_LAST) begin
            state_q     <= S_EMIT;
            out_valid_q <= 1'b1;
            out_data_q  <= res_d;
            out_row_q   <= i_q;
            out_col_q   <= j_q;
            out_last_q  <= (i_q == IDX_LAST) && (j_q == IDX_LAST);
            if (clamp_hi || clamp_lo) sat_q <= 1'b1;
`ifdef IDENTITY_CHECK_EN
            elem_sat_q <= clamp_hi || clamp_lo;
`endif
          end else begin
            k_q <= k_q + 3'd1;
          end
        end
        S_EMIT: begin
          if (hs_out) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
`ifdef IDENTITY_CHECK_EN
            ident_run_q <= ident_run_q && elem_ok;
`endif
            if (out_last_q) begin
              state_q    <= S_LOAD;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b0;
`ifdef IDENTITY_CHECK_EN
              is_identity_q <= ident_run_q && elem_ok;
`endif
            end else begin
              state_q <= S_MAC;
              acc_q   <= '0;
              k_q     <= '0;
              if (j_q == IDX_LAST) begin
                j_q <= '0;
                i_q <= i_q + 3'd1;
              end else begin
                j_q <= j_q + 3'd1;
              end
            end
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign out_last  = out_last_q;
  assign sat_flag  = sat_q;
  assign busy      = busy_q;

endmodule

// File: doc/matrix_multiply_check.md
Name: matrix_multiply_check

Overview:
- Sequential fixed-point N×N matrix multiplier computing C = A × B. It is the companion to the team's Gauss-Jordan inverse block: it applies a computed inverse, or proves one by checking that A × A⁻¹ equals I.
- Operands stream in over a valid/ready load port. One multiply-accumulate (MAC) executes per cycle. Results stream out row-major over a valid/ready port.

Parameters:
- N, 5, matrix dimension (2..8).
- DATA_W, 16, signed two's-complement element width.
- FRAC_W, 8, fractional bits (Q(DATA_W-FRAC_W).FRAC_W); 1.0 = 0x0100 at defaults.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  load word valid.
- in_ready  out  1  block accepts a load word.
- in_data  in  DATA_W  operand element: A row-major, then B row-major.
- out_valid  out  1  result element valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DATA_W  C[i][j], saturated.
- out_row  out  3  i of the current result.
- out_col  out  3  j of the current result.
- out_last  out  1  high with C[N-1][N-1].
- sat_flag  out  1  sticky: some element of the current product saturated.
- busy  out  1  high in the MAC and EMIT states.

Behaviour:
- States: LOAD, MAC, EMIT.
- Reset values: state=LOAD, in_ready=1, out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, sat_flag=0, busy=0, all counters 0. Reset wins over every other event in the same cycle, including mid-MAC and mid-EMIT. Partial results are discarded and the next load starts at A[0][0].
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready handshake writes the next element. The first N² words go to A, the next N² to B.
  - The handshake that carries word 2N²-1 moves the state to MAC, clears the accumulator, sets i=j=k=0, and clears sat_flag.
  - in_ready=0 in every other state.
- MAC:
  - Each cycle: acc += A[i][k]*B[k][j], then k++.
  - Accumulator width: 2·DATA_W + ceil(log2 N), signed. It never overflows.
  - The cycle with k=N-1 performs the final add and moves the state to EMIT.
- EMIT:
  - out_valid=1. out_data, out_row, out_col and out_last are registered.
  - Result = acc >>> FRAC_W (arithmetic shift, floor rounding). It is clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Clamping sets sat_flag. sat_flag stays set until the next product begins.
  - While out_ready=0, every output holds stable.
  - On out_valid&out_ready:
    - If not the last element: advance j (wrap to 0 and increment i), clear acc and k, return to MAC.
    - If the last element: go to LOAD with in_ready=1 on the next cycle. The A and B arrays are overwritten by the next load.
- Latency:
  - First out_valid rises N+1 cycles after the final load handshake.
  - Sustained rate with out_ready tied high: one result per N+1 cycles.
  - Whole product: N²·(N+1) cycles (150 at N=5).
- out_last=1 only for i=j=N-1.
- in_valid while in_ready=0 is ignored; data is not captured.

Optional Feature:
- Macro IDENTITY_CHECK_EN.
- When defined, add output is_identity (1 bit, reset 0) and parameter TOL (default 2, in LSBs).
  - During EMIT handshakes the block compares each result against 1.0 (diagonal) or 0 (off-diagonal) with |diff| ≤ TOL. A saturated element counts as a mismatch.
  - A register accumulates the AND of all comparisons.
  - is_identity updates on the cycle after the out_last handshake and holds until the next out_last handshake or reset.
- When not defined, neither the port nor the comparison logic exists.

Test Plan:
- Identity check: A=I (diagonal 0x0100), B=[k·0x0100 for k=0..24] → C equals B exactly in row-major order, out_last on element 24, sat_flag=0, first out_valid 6 cycles after the last load.
- Inverse proof: A = diagonal 1.0 with superdiagonal 2.0 (0x0200); B = entries (-2)^(j-i) for j≥i (0x0100, 0xFE00, 0x0400, 0xF800, 0x1000), 0 below the diagonal → C diagonal 0x0100, all else 0x0000; is_identity=1 with IDENTITY_CHECK_EN defined.
- Saturation: all A and B elements 0x7F00 → every out_data=0x7FFF, sat_flag=1. A following load with A=B=I → sat_flag=0, is_identity=1.
- Floor rounding: A=I·0xFF80 (-0.5), B=I·0x0001 → C diagonal 0xFFFF (floor of -1/512·256), off-diagonal 0.
- Backpressure: out_ready low for 10 cycles at C[2][3] → out_data, out_row=2, out_col=3 stable and no element skipped. Total cycles = 150 + 10.
- Reset mid-operation: rst pulsed during MAC of C[1][1] → the next cycle shows in_ready=1, out_valid=0, busy=0. A fresh 50-word load produces a correct full product.
